// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state encoding
// and the default register-index width.
package pipe_ctrl_pkg;

  localparam int REG_NUM_BITWIDTH_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, register enables/bubbles and
// statistics out. The master drives pipeline status; the slave is the controller.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEF,
  parameter int CNT_WIDTH        = 16
);
  logic [REG_NUM_BITWIDTH-1:0] id_rs1;
  logic [REG_NUM_BITWIDTH-1:0] id_rs2;
  logic                        id_uses_rs1;
  logic                        id_uses_rs2;
  logic                        ex_memRead;
  logic [REG_NUM_BITWIDTH-1:0] ex_rd;
  logic                        mem_memRead;
  logic                        mem_memWrite;
  logic                        mem_PCSrc;
  // Handshake: a MEM-stage access (mem_memRead|mem_memWrite) is the request and
  // completes in the cycle dmem_ready is 1; while it is 0 the pipeline holds.
  logic                        dmem_ready;

  logic                        pc_write;
  logic                        if_id_write;
  logic                        id_ex_write;
  logic                        ex_mem_write;
  logic                        if_id_flush;
  logic                        id_ex_nop;
  logic                        ex_mem_nop;
  logic                        mem_wb_nop;
  logic                        err;
  logic [CNT_WIDTH-1:0]        stall_cnt;
  logic [CNT_WIDTH-1:0]        flush_cnt;
  pipe_state_e                 state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memRead, ex_rd,
           mem_memRead, mem_memWrite, mem_PCSrc, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_nop, ex_mem_nop, mem_wb_nop, err, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memRead, ex_rd,
           mem_memRead, mem_memWrite, mem_PCSrc, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_nop, ex_mem_nop, mem_wb_nop, err, stall_cnt, flush_cnt, state
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait > branch flush >
// load-use, with a memory-timeout error state and saturating statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEF,
  parameter int MEM_TIMEOUT      = 16,
  parameter int CNT_WIDTH        = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  pipe_state_e                 state_q, state_d;
  logic [WAIT_W-1:0]           wait_cnt_q, wait_cnt_d;
  logic                        err_q, err_d;
  logic [REG_NUM_BITWIDTH-1:0] ex_rd_w;
  logic                        mem_op, lu;
  logic                        pc_write_w, if_id_write_w, id_ex_write_w, ex_mem_write_w;
  logic                        if_id_flush_w, id_ex_nop_w, ex_mem_nop_w, mem_wb_nop_w;

  assign ex_rd_w = hz.ex_rd;
  assign mem_op  = hz.mem_memRead | hz.mem_memWrite;
  assign lu      = hz.ex_memRead && (ex_rd_w != '0) &&
                   ((hz.id_uses_rs1 && hz.id_rs1 == ex_rd_w) ||
                    (hz.id_uses_rs2 && hz.id_rs2 == ex_rd_w));

  always_comb begin
    pc_write_w     = 1'b1;
    if_id_write_w  = 1'b1;
    id_ex_write_w  = 1'b1;
    ex_mem_write_w = 1'b1;
    if_id_flush_w  = 1'b0;
    id_ex_nop_w    = 1'b0;
    ex_mem_nop_w   = 1'b0;
    mem_wb_nop_w   = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    err_d          = err_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_op && !hz.dmem_ready) begin
          pc_write_w     = 1'b0;
          if_id_write_w  = 1'b0;
          id_ex_write_w  = 1'b0;
          ex_mem_write_w = 1'b0;
          mem_wb_nop_w   = 1'b1;
          wait_cnt_d     = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          // Release (or no wait): the branch/load-use rules apply this same cycle.
          state_d    = RUN;
          wait_cnt_d = '0;
          if (hz.mem_PCSrc) begin
            if_id_flush_w = 1'b1;
            id_ex_nop_w   = 1'b1;
            ex_mem_nop_w  = 1'b1;
          end else if (lu) begin
            pc_write_w    = 1'b0;
            if_id_write_w = 1'b0;
            id_ex_nop_w   = 1'b1;
          end
        end
      end
      ERROR: begin
        pc_write_w     = 1'b0;
        if_id_write_w  = 1'b0;
        id_ex_write_w  = 1'b0;
        ex_mem_write_w = 1'b0;
        mem_wb_nop_w   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!pc_write_w),
    .clr_i (1'b0),
    .cnt_o (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (if_id_flush_w),
    .clr_i (1'b0),
    .cnt_o (hz.flush_cnt)
  );

  assign hz.pc_write     = pc_write_w;
  assign hz.if_id_write  = if_id_write_w;
  assign hz.id_ex_write  = id_ex_write_w;
  assign hz.ex_mem_write = ex_mem_write_w;
  assign hz.if_id_flush  = if_id_flush_w;
  assign hz.id_ex_nop    = id_ex_nop_w;
  assign hz.ex_mem_nop   = ex_mem_nop_w;
  assign hz.mem_wb_nop   = mem_wb_nop_w;
  assign hz.err          = err_q;
  assign hz.state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table for the combinational priority mux
// plus hand sequences for multi-cycle load-use, memory wait, timeout, saturation.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ex_mr;
    logic [4:0] ex_rd;
    logic       mr;
    logic       mw;
    logic       pcsrc;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    stim_t      in;
    logic [8:0] exp;
  } vec_t;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_nop, ex_mem_nop, mem_wb_nop, err}
  localparam logic [8:0] E_DEF = 9'b1111_0000_0;
  localparam logic [8:0] E_LU  = 9'b0011_0100_0;
  localparam logic [8:0] E_BR  = 9'b1111_1110_0;
  localparam logic [8:0] E_MW  = 9'b0000_0001_0;
  localparam logic [8:0] E_ER  = 9'b0000_0001_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [8:0] exp_q[$];
  vec_t tbl[10];

  pipe_hazard_ctrl_if #(.REG_NUM_BITWIDTH(5), .CNT_WIDTH(2)) hz ();

  pipe_hazard_ctrl #(
    .REG_NUM_BITWIDTH(5),
    .MEM_TIMEOUT     (4),
    .CNT_WIDTH       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic ex_mr,
                               input logic [4:0] ex_rd, input logic mr, input logic mw,
                               input logic pcsrc, input logic rdy);
    stim_t s;
    s = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, ex_mr: ex_mr, ex_rd: ex_rd,
          mr: mr, mw: mw, pcsrc: pcsrc, rdy: rdy};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    hz.id_rs1       = s.rs1;
    hz.id_rs2       = s.rs2;
    hz.id_uses_rs1  = s.u1;
    hz.id_uses_rs2  = s.u2;
    hz.ex_memRead   = s.ex_mr;
    hz.ex_rd        = s.ex_rd;
    hz.mem_memRead  = s.mr;
    hz.mem_memWrite = s.mw;
    hz.mem_PCSrc    = s.pcsrc;
    hz.dmem_ready   = s.rdy;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic apply(input stim_t s, input logic [8:0] e, input string nm);
    logic [8:0] got;
    drive(s);
    exp_q.push_back(e);
    @(negedge clk);
    got = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
           hz.if_id_flush, hz.id_ex_nop, hz.ex_mem_nop, hz.mem_wb_nop, hz.err};
    check(nm, 32'(got), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    #2;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  stim_t z;
  stim_t lu5;

  initial begin
    z   = '0;
    lu5 = mk(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, inputs all zero.
    drive(z);
    #2;
    check("rst_outputs", 32'({hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
                              hz.if_id_flush, hz.id_ex_nop, hz.ex_mem_nop, hz.mem_wb_nop, hz.err}),
          32'(E_DEF));
    check("rst_state", 32'(hz.state), 32'(RUN));
    check("rst_cnts", 32'({hz.stall_cnt, hz.flush_cnt}), 32'h0);
    do_reset();

    // Table: single-cycle patterns that leave the FSM in RUN.
    tbl[0] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_DEF};
    tbl[1] = '{mk(5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), E_LU};
    tbl[2] = '{mk(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), E_LU};
    tbl[3] = '{mk(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), E_DEF};
    tbl[4] = '{mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_DEF};
    tbl[5] = '{mk(5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0), E_DEF};
    tbl[6] = '{mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0), E_BR};
    tbl[7] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), E_DEF};
    tbl[8] = '{mk(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1), E_LU};
    tbl[9] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), E_BR};
    for (int i = 0; i < 10; i++) apply(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
    check("vec_state", 32'(hz.state), 32'(RUN));

    // Random non-hazard patterns: no load in EX, no branch, memory ready.
    for (int i = 0; i < 8; i++)
      apply(mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0,
               5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1),
            E_DEF, $sformatf("rnd%0d", i));

    // Load-use: one bubble, then the load has moved on.
    do_reset();
    apply(lu5, E_LU, "lu_stall");
    apply(z, E_DEF, "lu_after");
    check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // Zero destination register never stalls.
    do_reset();
    apply(mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_DEF, "zero_rd");
    check("zero_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    // Branch overrides a simultaneous load-use.
    do_reset();
    apply(mk(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0), E_BR, "br_lu");
    check("br_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    // Memory wait: 3 stalled cycles then release.
    do_reset();
    for (int i = 0; i < 3; i++)
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_MW, $sformatf("mw%0d", i));
    check("mw_state_wait", 32'(hz.state), 32'(MEM_WAIT));
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), E_DEF, "mw_release");
    check("mw_state_run", 32'(hz.state), 32'(RUN));
    check("mw_stall_cnt", 32'(hz.stall_cnt), 32'd3);

    // Branch seen during a wait is held off until release.
    do_reset();
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), E_MW, "mwbr0");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), E_MW, "mwbr1");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), E_BR, "mwbr_rel");
    check("mwbr_flush_cnt", 32'(hz.flush_cnt), 32'd1);

    // Timeout after 4 stalled cycles, sticky until reset.
    do_reset();
    for (int i = 0; i < 3; i++)
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_MW, $sformatf("to%0d", i));
    check("to_not_yet", 32'(hz.state), 32'(MEM_WAIT));
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_MW, "to3");
    check("to_state_err", 32'(hz.state), 32'(ERROR));
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), E_ER, "err_hold0");
    apply(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0), E_ER, "err_hold1");
    check("err_stall_sat", 32'(hz.stall_cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("err_rst_err", 32'(hz.err), 32'd0);
    check("err_rst_state", 32'(hz.state), 32'(RUN));
    check("err_rst_cnts", 32'({hz.stall_cnt, hz.flush_cnt}), 32'h0);
    do_reset();

    // Saturation: 5 load-use stalls in a 2-bit counter.
    for (int i = 0; i < 5; i++) apply(lu5, E_LU, $sformatf("sat%0d", i));
    check("sat_stall_cnt", 32'(hz.stall_cnt), 32'd3);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
